seq_detect_moore_param: RTL and testbench
=========================================

// Module: seq_detect_moore_param
// PURPOSE
//   Parametrised Moore serial-pattern detector. Successor to the fixed
//   4-bit 1011 non-overlapping detector. Pattern value and length are
//   set by parameters. Overlap mode is selected at run time.
//   Adds an input-valid qualifier and a saturating match counter.
//   Sits on a 1-bit serial data path, clocked by the data-sampling clock.
// PARAMETERS
//   PATTERN_LEN  4        pattern length in bits; legal range 2..16
//   PATTERN      4'b1011  pattern value; PATTERN[PATTERN_LEN-1] is received first
//   CNT_W        8        width of match_count
// PORTS
//   clk          input   1      rising-edge clock
//   reset        input   1      asynchronous, active-high reset
//   din          input   1      serial data bit
//   din_valid    input   1      din is sampled only when this is 1
//   overlap_en   input   1      1 = overlapping detection, 0 = non-overlapping
//   count_clr    input   1      synchronous clear of match_count
//   y            output  1      detect flag (Moore output, decoded from state)
//   match_count  output  CNT_W  saturating count of detections
// BEHAVIOUR
//   - Reset: state=S0, y=0, match_count=0. Reset takes effect immediately,
//     including in the middle of a pattern. Any partial match is discarded.
//   - States S0..S<PATTERN_LEN>: Sk means the first k pattern bits are matched.
//     y=1 only in state S<PATTERN_LEN> (SD). y has no combinational path from din.
//   - Each edge with din_valid=1: let e = the next expected pattern bit.
//     * Sk (k<LEN), din==e: go to Sk+1.
//     * Sk, din!=e: go to Sj, where j is the length of the longest pattern prefix
//       that is a suffix of (the k matched bits followed by din). This is the
//       KMP fallback. Compute it at elaboration (function or generate).
//     * SD: first choose a base state. overlap_en=1 gives base = S<f>, where f is
//       the longest proper prefix of the pattern that is also its suffix.
//       overlap_en=0 gives base = S0. Then apply the Sk rules above from the base.
//   - din_valid=0: state holds, so y holds. This includes staying in SD with y=1.
//   - Latency: y=1 in the cycle after the edge that samples the final pattern bit.
//     y lasts exactly one cycle if din_valid stays 1 and the next bit gives no
//     new match.
//   - overlap_en matters only on transitions out of SD. It may change at any
//     time without corrupting state.
//   - match_count increments by 1 on each edge that enters SD.
//     * It saturates at 2^CNT_W-1 and never wraps.
//     * count_clr=1 has priority over the increment: the count becomes 0 and the
//       simultaneous match is not counted.
//     * count_clr does not affect the state or y.
//   - Elaboration error if PATTERN_LEN is outside 2..16.
// TESTING
//   1 Defaults, overlap_en=0, din_valid=1, din=1011011011 (first bit first).
//     -> y high after bits 4 and 10. match_count=2.
//   2 Same stream with overlap_en=1.
//     -> y high after bits 4, 7 and 10. match_count=3.
//   3 Stream 10 with din_valid=0 for 3 cycles, then 11 with din_valid=1.
//     -> y high after the 4th valid bit. No state change while din_valid=0.
//   4 Feed 101, assert reset mid-cycle, release, then feed 1.
//     -> y, match_count and state read 0 immediately. No detection afterwards.
//   5 CNT_W=2, overlap_en=1, din=1011 repeated 5 times.
//     -> match_count saturates at 3. Then count_clr on the edge of a match
//        -> match_count=0.
//   6 PATTERN_LEN=3, PATTERN=3'b111, overlap_en=1, din=11111.
//     -> y high after bits 3, 4 and 5. With overlap_en=0: after bit 3 only.

Source files
------------

// File: rtl/seq_detect_moore_param.sv
// rtl/seq_detect_moore_param.sv - parametrised Moore serial-pattern detector with valid qualifier and saturating match counter
module seq_detect_moore_param #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter int                     CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             overlap_en,
  input  logic             count_clr,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);

  generate
    if (PATTERN_LEN < 2 || PATTERN_LEN > 16) begin : g_bad_len
      $error("seq_detect_moore_param: PATTERN_LEN must be in 2..16");
    end
  endgenerate

  typedef enum logic [4:0] {
    S0, S1, S2, S3, S4, S5, S6, S7, S8,
    S9, S10, S11, S12, S13, S14, S15, S16
  } state_t;

  localparam logic [15:0] PAT16 = 16'(PATTERN);
  localparam state_t      SD    = state_t'(PATTERN_LEN);

  // Bit i of the pattern in arrival order (i = 0 is received first).
  function automatic logic pat_bit(input int i);
    int idx;
    idx = PATTERN_LEN - 1 - i;
    return PAT16[idx[3:0]];
  endfunction

  // Longest pattern prefix that is a suffix of (first k pattern bits, then b).
  function automatic logic [4:0] kmp_next(input int k, input logic b);
    logic ok;
    logic sb;
    int   s;
    kmp_next = '0;
    for (int j = 1; j <= 16; j++) begin
      if (j <= k + 1 && j <= PATTERN_LEN) begin
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
          if (i < j) begin
            s  = k + 1 - j + i;
            sb = (s < k) ? pat_bit(s) : b;
            if (sb != pat_bit(i)) ok = 1'b0;
          end
        end
        if (ok) kmp_next = 5'(j);
      end
    end
  endfunction

  // Longest proper prefix of the pattern that is also its suffix.
  function automatic int border_len();
    logic ok;
    border_len = 0;
    for (int j = 1; j < 16; j++) begin
      if (j < PATTERN_LEN) begin
        ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
          if (i < j && pat_bit(i) != pat_bit(PATTERN_LEN - j + i)) ok = 1'b0;
        end
        if (ok) border_len = j;
      end
    end
  endfunction

  localparam int BORDER = border_len();

  // Entry (2*k + b): next state from Sk on bit b; the SD row holds the overlapping fallback.
  function automatic logic [169:0] build_tbl();
    int kk;
    build_tbl = '0;
    for (int k = 0; k <= 16; k++) begin
      if (k <= PATTERN_LEN) begin
        kk = (k == PATTERN_LEN) ? BORDER : k;
        build_tbl[(2*k)*5 +: 5]   = kmp_next(kk, 1'b0);
        build_tbl[(2*k+1)*5 +: 5] = kmp_next(kk, 1'b1);
      end
    end
  endfunction

  localparam logic [169:0] NXT_TBL = build_tbl();

  state_t             state_q, state_d;
  logic               y_q, y_d;
  logic [CNT_W-1:0]   match_count_q, match_count_d;
  logic [4:0]         row;
  logic [7:0]         sel;

  always_comb begin
    state_d       = state_q;
    row           = state_q;
    sel           = '0;
    if (din_valid) begin
      // Non-overlapping exit from SD restarts the search from S0.
      if (state_q == SD && !overlap_en) row = 5'd0;
      sel     = 8'({row, din}) * 8'd5;
      state_d = state_t'(NXT_TBL[sel +: 5]);
    end
    y_d           = (state_d == SD);
    match_count_d = match_count_q;
    if (count_clr) begin
      match_count_d = '0;
    end else if (din_valid && state_d == SD && match_count_q != '1) begin
      match_count_d = match_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S0;
      y_q           <= 1'b0;
      match_count_q <= '0;
    end else begin
      state_q       <= state_d;
      y_q           <= y_d;
      match_count_q <= match_count_d;
    end
  end

  assign y           = y_q;
  assign match_count = match_count_q;

endmodule

// File: tb/tb_seq_detect_moore_param.sv
// tb/tb_seq_detect_moore_param.sv - self-checking bench for seq_detect_moore_param
module tb_seq_detect_moore_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       din, din_valid, overlap_en, count_clr;
  logic       y0, y1, y2;
  logic [7:0] mc0, mc2;
  logic [1:0] mc1;

  always #5 clk = ~clk;

  seq_detect_moore_param dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .overlap_en(overlap_en), .count_clr(count_clr), .y(y0), .match_count(mc0)
  );

  seq_detect_moore_param #(.CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .overlap_en(overlap_en), .count_clr(count_clr), .y(y1), .match_count(mc1)
  );

  seq_detect_moore_param #(.PATTERN_LEN(3), .PATTERN(3'b111)) dut_p (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
    .overlap_en(overlap_en), .count_clr(count_clr), .y(y2), .match_count(mc2)
  );

  int tests = 0;
  int fails = 0;

  // Reference: a match is the last LEN valid bits equalling the pattern, using only
  // bits received since the search start; a non-overlapping exit moves the start.
  int plen [3] = '{4, 4, 3};
  int pat  [3] = '{11, 11, 7};
  int cmax [3] = '{255, 3, 255};
  int avail[3];
  int hist [3];
  bit det  [3];
  int cnt  [3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      avail[i] = 0; hist[i] = 0; det[i] = 1'b0; cnt[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (din_valid) begin
        if (det[i] && !overlap_en) avail[i] = 0;
        hist[i]  = ((hist[i] << 1) | int'(din)) & 16'hffff;
        avail[i] = avail[i] + 1;
        det[i]   = (avail[i] >= plen[i]) && ((hist[i] & ((1 << plen[i]) - 1)) == pat[i]);
      end
      if (count_clr) cnt[i] = 0;
      else if (din_valid && det[i] && cnt[i] < cmax[i]) cnt[i] = cnt[i] + 1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y0"},  32'(y0),  32'(det[0]));
    check({tag, ".mc0"}, 32'(mc0), 32'(cnt[0]));
    check({tag, ".y1"},  32'(y1),  32'(det[1]));
    check({tag, ".mc1"}, 32'(mc1), 32'(cnt[1]));
    check({tag, ".y2"},  32'(y2),  32'(det[2]));
    check({tag, ".mc2"}, 32'(mc2), 32'(cnt[2]));
  endtask

  task automatic step(input logic d, input logic v, input logic ov, input logic clr, input string tag);
    din = d; din_valid = v; overlap_en = ov; count_clr = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
    reset = 1'b0;
  endtask

  task automatic feed(input logic [31:0] bits, input int n, input logic ov, input string tag);
    for (int i = n - 1; i >= 0; i--) step(bits[i], 1'b1, ov, 1'b0, tag);
  endtask

  initial begin
    reset = 1'b1; din = 1'b0; din_valid = 1'b0; overlap_en = 1'b0; count_clr = 1'b0;
    model_reset();
    #2;
    check_all("async_reset");
    do_reset();

    feed(32'b1011011011, 10, 1'b0, "t1");
    check("t1_count", 32'(mc0), 32'd2);

    do_reset();
    feed(32'b1011011011, 10, 1'b1, "t2");
    check("t2_count", 32'(mc0), 32'd3);

    do_reset();
    feed(32'b10, 2, 1'b0, "t3a");
    for (int i = 0; i < 3; i++) step(1'($urandom_range(1)), 1'b0, 1'b0, 1'b0, "t3_hold");
    feed(32'b11, 2, 1'b0, "t3b");
    check("t3_y", 32'(y0), 32'd1);
    step(1'b1, 1'b0, 1'b0, 1'b0, "t3_sd_hold");
    check("t3_y_hold", 32'(y0), 32'd1);

    do_reset();
    feed(32'b101, 3, 1'b0, "t4");
    #3;
    reset = 1'b1;
    #1;
    check("t4_y", 32'(y0), 32'd0);
    check("t4_mc", 32'(mc0), 32'd0);
    check("t4_state", 32'(dut.state_q), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, "t4_after");
    check("t4_no_det", 32'(y0), 32'd0);

    do_reset();
    for (int r = 0; r < 5; r++) feed(32'b1011, 4, 1'b1, "t5");
    check("t5_sat", 32'(mc1), 32'd3);
    feed(32'b101, 3, 1'b1, "t5b");
    step(1'b1, 1'b1, 1'b1, 1'b1, "t5_clr");
    check("t5_clr_mc", 32'(mc1), 32'd0);
    check("t5_clr_y", 32'(y1), 32'd1);

    do_reset();
    feed(32'b11111, 5, 1'b1, "t6a");
    check("t6_ov_count", 32'(mc2), 32'd3);
    do_reset();
    feed(32'b11111, 5, 1'b0, "t6b");
    check("t6_nov_count", 32'(mc2), 32'd1);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(1)), 1'($urandom_range(9) < 8),
           1'($urandom_range(3) != 0), 1'($urandom_range(99) < 3), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
